// File: rtl/flop_to_int.sv
// Sequential 13-bit float {sign, exp[7:0], mant[3:0]} to 16-bit signed integer converter.
// Build option: define FLOP_ROUND_EN for round-half-away-from-zero; otherwise truncates toward zero.
module flop_to_int (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_ovf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  dbgState
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // out_data/out_ovf hold steady while out_valid is 1 and out_ready is 0.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIX   = 2'd2,
    DONE  = 2'd3
  } stateT;

  stateT state, nextState;

  logic [7:0]  expF;
  logic [3:0]  mant;
  logic        accept;
  logic        decZero, decSat, decLeft, decOvf;
  logic [3:0]  decK;

  logic [15:0] mag;
  logic [3:0]  cnt;
  logic        dirLeft;
  logic        signR;
  logic        satR;
  logic        ovfR;
  logic [15:0] rounded;
  logic [15:0] fixVal;
`ifdef FLOP_ROUND_EN
  logic        guard;
`endif

  assign expF      = in_data[11:4];
  assign mant      = in_data[3:0];
  assign in_ready  = rst_n && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign dbgState  = state;

  // mag holds 1.mmmm scaled by 16, so the integer is mag * 2^(exp-131).
  always_comb begin
    decZero = 1'b0;
    decSat  = 1'b0;
    decLeft = 1'b0;
    decK    = 4'd0;
    if (expF <= 8'd125) begin
      decZero = 1'b1;
    end else if (expF == 8'd126) begin
      decK = 4'd5;
    end else if (expF <= 8'd130) begin
      decK = 4'd3 - expF[3:0];
    end else if (expF <= 8'd141) begin
      decLeft = 1'b1;
      decK    = expF[3:0] - 4'd3;
    end else begin
      decSat = 1'b1;
    end
    // -32768 is the one saturating input that is exactly representable.
    decOvf = decSat && !(in_data[12] && (expF == 8'd142) && (mant == 4'd0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (accept) nextState = (decK != 4'd0) ? SHIFT : FIX;
      SHIFT: if (cnt == 4'd1) nextState = FIX;
      FIX:   nextState = DONE;
      DONE:  if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
`ifdef FLOP_ROUND_EN
    rounded = mag + {15'd0, guard};
`else
    rounded = mag;
`endif
    fixVal = signR ? (~rounded + 16'd1) : rounded;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag      <= 16'd0;
      cnt      <= 4'd0;
      dirLeft  <= 1'b0;
      signR    <= 1'b0;
      satR     <= 1'b0;
      ovfR     <= 1'b0;
      out_data <= 16'd0;
      out_ovf  <= 1'b0;
`ifdef FLOP_ROUND_EN
      guard    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mag     <= decZero ? 16'd0 : {11'd0, 1'b1, mant};
            cnt     <= decK;
            dirLeft <= decLeft;
            signR   <= in_data[12];
            satR    <= decSat;
            ovfR    <= decOvf;
`ifdef FLOP_ROUND_EN
            guard   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          mag <= dirLeft ? {mag[14:0], 1'b0} : {1'b0, mag[15:1]};
          cnt <= cnt - 4'd1;
`ifdef FLOP_ROUND_EN
          if (!dirLeft) guard <= mag[0];
`endif
        end
        FIX: begin
          out_data <= satR ? (signR ? 16'h8000 : 16'h7FFF) : fixVal;
          out_ovf  <= ovfR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flop_to_int.sv
// Scoreboard bench for flop_to_int: driver pushes expected results, a negedge monitor pops and compares.
module tb_flop_to_int;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] in_data = 13'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  dbgState;

  flop_to_int dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dbgState (dbgState)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [16:0] exp_q[$];
  int          rise_q[$];
  int          tests = 0;
  int          fails = 0;
  int          accepts = 0;
  int          sent = 0;
  logic        prevValid = 1'b0;

`ifdef FLOP_ROUND_EN
  localparam logic [15:0] R25  = 16'd3;
  localparam logic [15:0] R05  = 16'd1;
  localparam logic [15:0] RN25 = 16'hFFFD;
`else
  localparam logic [15:0] R25  = 16'd2;
  localparam logic [15:0] R05  = 16'd0;
  localparam logic [15:0] RN25 = 16'hFFFE;
`endif

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  // Called at posedge+#1; leaves the caller at posedge+#1 just after the accept edge.
  task automatic send_word(input logic [12:0] w, input logic [15:0] expData, input logic expOvf,
                           input int k, input bit track, input bit holdValid);
    int t = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    sent++;
    if (track) begin
      exp_q.push_back({expOvf, expData});
      rise_q.push_back(cyc + k + 1);
    end
    if (!holdValid) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prevValid = 1'b0;
    end else begin
      if (in_valid && in_ready) accepts++;
      if (out_valid && !prevValid) begin
        if (rise_q.size() != 0) check("latency", cyc, rise_q.pop_front());
        else check("spurious_valid", 1, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("out_data", int'(out_data), int'(e[15:0]));
          check("out_ovf", int'(out_ovf), int'(e[16]));
        end else begin
          check("unexpected_output", 1, 0);
        end
      end
      prevValid = out_valid;
    end
  end

  typedef struct {
    logic [12:0] w;
    logic [15:0] d;
    logic        o;
    int          k;
  } vecT;

  vecT vecs[$];

  initial begin
    vecs = '{
      '{13'h07F0, 16'd1,     1'b0, 4},
      '{13'h0804, R25,       1'b0, 3},
      '{13'h07E0, R05,       1'b0, 5},
      '{13'h1804, RN25,      1'b0, 3},
      '{13'h0000, 16'd0,     1'b0, 0},
      '{13'h0960, 16'h7FFF,  1'b1, 0},
      '{13'h18E0, 16'h8000,  1'b0, 0},
      '{13'h0890, 16'd1024,  1'b0, 6},
      '{13'h08D5, 16'd21504, 1'b0, 10},
      '{13'h18F0, 16'h8000,  1'b1, 0},
      '{13'h18E1, 16'h8000,  1'b1, 0},
      '{13'h07D0, 16'd0,     1'b0, 0},
      '{13'h0FF0, 16'h7FFF,  1'b1, 0},
      '{13'h1FF0, 16'h8000,  1'b1, 0},
      '{13'h0830, 16'd16,    1'b0, 0},
      '{13'h188F, 16'hFC20,  1'b0, 5}
    };

    // reset state
    #12;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_ovf", int'(out_ovf), 0);
    check("rst_state", int'(dbgState), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", int'(in_ready), 1);

    // directed: 1.0 and -992 with latency checks
    send_word(13'h07F0, 16'd1, 1'b0, 4, 1'b1, 1'b0);
    wait_drain();

    // stall with out_ready low for 3 cycles
    out_ready = 1'b0;
    send_word(13'h188F, 16'hFC20, 1'b0, 5, 1'b1, 1'b0);
    begin
      int t = 0;
      while (!out_valid && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      check("stall_valid_seen", int'(out_valid), 1);
      for (int i = 0; i < 3; i++) begin
        in_valid = 1'b1;
        in_data  = 13'h0808;
        check("stall_data", int'(out_data), 16'hFC20);
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_state", int'(dbgState), 3);
        @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    wait_drain();

    // saturation, exact minimum, rounding cases, zero
    send_word(13'h0960, 16'h7FFF, 1'b1, 0, 1'b1, 1'b0);
    send_word(13'h18E0, 16'h8000, 1'b0, 0, 1'b1, 1'b0);
    send_word(13'h0804, R25, 1'b0, 3, 1'b1, 1'b0);
    send_word(13'h07E0, R05, 1'b0, 5, 1'b1, 1'b0);
    send_word(13'h0000, 16'd0, 1'b0, 0, 1'b1, 1'b0);
    wait_drain();

    // reset in the middle of a shift sequence
    send_word(13'h0A10, 16'h7FFF, 1'b1, 0, 1'b1, 1'b0);
    wait_drain();
    send_word(13'h08A0, 16'd0, 1'b0, 7, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_state", int'(dbgState), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_state", int'(dbgState), 0);
    check("mid_rst_in_ready", int'(in_ready), 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    send_word(13'h0808, 16'd3, 1'b0, 3, 1'b1, 1'b0);
    wait_drain();

    // back-to-back stream with in_valid held high
    out_ready = 1'b1;
    foreach (vecs[i]) send_word(vecs[i].w, vecs[i].d, vecs[i].o, vecs[i].k, 1'b1, 1'b1);
    in_valid = 1'b0;
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    check("accept_count", accepts, sent);
    check("rise_q_empty", rise_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
